l1_miss_status_queue: RTL and testbench

Parametrised successor to the per-thread L1 load miss tracker. It decouples entry count from thread count and holds up to NUM_ENTRIES outstanding line misses. Non-synchronized misses to the same line are merged into one entry, and full back-pressure is reported. Sits between the L1 data cache tag stage and the L2 request interface: it issues one L2 request per entry, wakes all waiting threads on the L2 response, and supports per-thread cancellation for rollback/kill.

---
 rtl/l1_miss_status_queue_if.sv | 41 ++++
 rtl/l1_miss_status_queue.sv | 147 ++++++++++++++
 tb/tb_l1_miss_status_queue.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_miss_status_queue_if.sv
// Bundles the tag-stage enqueue, L2 dequeue/response and cancel signals of the miss status queue.
// The cache/L2 side uses the master modport and the queue itself uses the slave modport.
interface l1_miss_status_queue_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 26,
    parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
);
    localparam int TID_WIDTH = $clog2(NUM_THREADS);

    logic                   cache_miss;
    logic [ADDR_WIDTH-1:0]  cache_miss_addr;
    logic [TID_WIDTH-1:0]   cache_miss_thread_idx;
    logic                   cache_miss_synchronized;
    logic                   miss_ready;
    logic                   dequeue_ready;
    logic                   dequeue_ack;
    logic [ADDR_WIDTH-1:0]  dequeue_addr;
    logic [IDX_WIDTH-1:0]   dequeue_idx;
    logic                   dequeue_synchronized;
    logic                   l2_response_valid;
    logic [IDX_WIDTH-1:0]   l2_response_idx;
    logic [NUM_THREADS-1:0] wake_bitmap;
    logic                   cancel_valid;
    logic [TID_WIDTH-1:0]   cancel_thread_idx;
    logic [IDX_WIDTH:0]     occupancy;

    modport master (
        output cache_miss, cache_miss_addr, cache_miss_thread_idx, cache_miss_synchronized,
        output dequeue_ack, l2_response_valid, l2_response_idx, cancel_valid, cancel_thread_idx,
        input  miss_ready, dequeue_ready, dequeue_addr, dequeue_idx, dequeue_synchronized,
        input  wake_bitmap, occupancy
    );

    modport slave (
        input  cache_miss, cache_miss_addr, cache_miss_thread_idx, cache_miss_synchronized,
        input  dequeue_ack, l2_response_valid, l2_response_idx, cancel_valid, cancel_thread_idx,
        output miss_ready, dequeue_ready, dequeue_addr, dequeue_idx, dequeue_synchronized,
        output wake_bitmap, occupancy
    );
endinterface

// File: rtl/l1_miss_status_queue.sv
// Outstanding L1 line-miss tracker: merges same-line misses, issues one L2 request per entry
// in round-robin order, and wakes every waiting thread when the fill returns.
module l1_miss_status_queue #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 26,
    parameter int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
    input logic                  clk,
    input logic                  reset,
    l1_miss_status_queue_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SENT
    } entryState_t;

    entryState_t            entryState_q  [NUM_ENTRIES];
    entryState_t            entryState_d  [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  entryAddr_q   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]  entryAddr_d   [NUM_ENTRIES];
    logic                   entrySync_q   [NUM_ENTRIES];
    logic                   entrySync_d   [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] waitThreads_q [NUM_ENTRIES];
    logic [NUM_THREADS-1:0] waitThreads_d [NUM_ENTRIES];
    logic [IDX_WIDTH-1:0]   rrPtr_q, rrPtr_d;
    logic [IDX_WIDTH:0]     occupancy_q, occupancy_d;

    logic [NUM_ENTRIES-1:0] matchVec;
    logic                   matchAny, allocAny, grantValid;
    logic [IDX_WIDTH-1:0]   matchIdx, allocIdx, grantIdx;
    logic                   doMerge, doAlloc, doAck, doResp;
    logic [NUM_THREADS-1:0] threadOneHot, cancelMask;
    int                     scanIdx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entryState_q[i]  <= ST_IDLE;
                entryAddr_q[i]   <= '0;
                entrySync_q[i]   <= 1'b0;
                waitThreads_q[i] <= '0;
            end
            rrPtr_q     <= '0;
            occupancy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entryState_q[i]  <= entryState_d[i];
                entryAddr_q[i]   <= entryAddr_d[i];
                entrySync_q[i]   <= entrySync_d[i];
                waitThreads_q[i] <= waitThreads_d[i];
            end
            rrPtr_q     <= rrPtr_d;
            occupancy_q <= occupancy_d;
        end
    end

    // An entry being filled this cycle is neither a merge target nor reusable until the next cycle.
    always_comb begin
        matchVec   = '0;
        matchAny   = 1'b0;
        matchIdx   = '0;
        allocAny   = 1'b0;
        allocIdx   = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        scanIdx    = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            matchVec[i] = (entryState_q[i] != ST_IDLE) && (entryAddr_q[i] == bus.cache_miss_addr)
                       && !entrySync_q[i] && !bus.cache_miss_synchronized
                       && !(bus.l2_response_valid && (bus.l2_response_idx == IDX_WIDTH'(i)));
            if (matchVec[i]) begin
                matchAny = 1'b1;
                matchIdx = IDX_WIDTH'(i);
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entryState_q[i] == ST_IDLE) begin
                allocAny = 1'b1;
                allocIdx = IDX_WIDTH'(i);
            end
        end
        // Scan backwards from the farthest slot so the pending entry nearest the pointer wins.
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            scanIdx = int'(rrPtr_q) + k;
            if (scanIdx >= NUM_ENTRIES) scanIdx = scanIdx - NUM_ENTRIES;
            if (entryState_q[scanIdx] == ST_PENDING) begin
                grantValid = 1'b1;
                grantIdx   = IDX_WIDTH'(scanIdx);
            end
        end
        doMerge      = bus.cache_miss && matchAny;
        doAlloc      = bus.cache_miss && !matchAny && allocAny;
        doAck        = bus.dequeue_ack && grantValid;
        doResp       = bus.l2_response_valid;
        threadOneHot = NUM_THREADS'(1) << bus.cache_miss_thread_idx;
        cancelMask   = bus.cancel_valid ? ~(NUM_THREADS'(1) << bus.cancel_thread_idx) : '1;
    end

    // Cancel is applied first so that a same-cycle merge of that thread leaves its bit set.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entryState_d[i]  = entryState_q[i];
            entryAddr_d[i]   = entryAddr_q[i];
            entrySync_d[i]   = entrySync_q[i];
            waitThreads_d[i] = waitThreads_q[i] & cancelMask;
            if (doMerge && (matchIdx == IDX_WIDTH'(i))) begin
                waitThreads_d[i] = waitThreads_d[i] | threadOneHot;
            end
            if (doAlloc && (allocIdx == IDX_WIDTH'(i))) begin
                entryState_d[i]  = ST_PENDING;
                entryAddr_d[i]   = bus.cache_miss_addr;
                entrySync_d[i]   = bus.cache_miss_synchronized;
                waitThreads_d[i] = threadOneHot;
            end
            if (doAck && (grantIdx == IDX_WIDTH'(i))) begin
                entryState_d[i] = ST_SENT;
            end
            if (doResp && (bus.l2_response_idx == IDX_WIDTH'(i))) begin
                entryState_d[i]  = ST_IDLE;
                waitThreads_d[i] = '0;
            end
        end
        rrPtr_d = rrPtr_q;
        if (doAck) begin
            rrPtr_d = (grantIdx == IDX_WIDTH'(NUM_ENTRIES - 1)) ? '0 : grantIdx + IDX_WIDTH'(1);
        end
        occupancy_d = occupancy_q + (IDX_WIDTH + 1)'(doAlloc) - (IDX_WIDTH + 1)'(doResp);
    end

    always_comb begin
        bus.miss_ready           = matchAny || allocAny;
        bus.dequeue_ready        = grantValid;
        bus.dequeue_addr         = entryAddr_q[grantIdx];
        bus.dequeue_idx          = grantIdx;
        bus.dequeue_synchronized = entrySync_q[grantIdx];
        bus.wake_bitmap          = bus.l2_response_valid
                                 ? (waitThreads_q[bus.l2_response_idx] & cancelMask) : '0;
        bus.occupancy            = occupancy_q;
    end

    assert property (@(posedge clk) disable iff (reset) bus.dequeue_ack |-> bus.dequeue_ready);
    assert property (@(posedge clk) disable iff (reset)
        bus.l2_response_valid |-> (entryState_q[bus.l2_response_idx] == ST_SENT));
    assert property (@(posedge clk) disable iff (reset) $onehot0(matchVec));
endmodule

// File: tb/tb_l1_miss_status_queue.sv
// Directed bench for l1_miss_status_queue: allocation, merge, full back-pressure,
// round-robin dequeue, responses, cancellation and reset, against hand-computed values.
module tb_l1_miss_status_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    l1_miss_status_queue_if bus ();

    l1_miss_status_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        bus.cache_miss              = 1'b0;
        bus.cache_miss_addr         = '0;
        bus.cache_miss_thread_idx   = '0;
        bus.cache_miss_synchronized = 1'b0;
        bus.dequeue_ack             = 1'b0;
        bus.l2_response_valid       = 1'b0;
        bus.l2_response_idx         = '0;
        bus.cancel_valid            = 1'b0;
        bus.cancel_thread_idx       = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic applyMiss(input logic [25:0] addr, input logic [1:0] tid, input logic sync);
        bus.cache_miss              = 1'b1;
        bus.cache_miss_addr         = addr;
        bus.cache_miss_thread_idx   = tid;
        bus.cache_miss_synchronized = sync;
    endtask

    task automatic applyResponse(input logic [2:0] idx);
        bus.l2_response_valid = 1'b1;
        bus.l2_response_idx   = idx;
    endtask

    task automatic applyCancel(input logic [1:0] tid);
        bus.cancel_valid      = 1'b1;
        bus.cancel_thread_idx = tid;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_deq_ready", 32'(bus.dequeue_ready), 32'd0);
        checkOutput("rst_wake", 32'(bus.wake_bitmap), 32'd0);
        checkOutput("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
        checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);

        // Single miss: visible on the dequeue side one cycle later.
        applyMiss(26'h100, 2'd0, 1'b0);
        #1;
        checkOutput("t1_miss_ready", 32'(bus.miss_ready), 32'd1);
        checkOutput("t1_latency", 32'(bus.dequeue_ready), 32'd0);
        nextCycle();
        #1;
        checkOutput("t1_deq_ready", 32'(bus.dequeue_ready), 32'd1);
        checkOutput("t1_deq_addr", 32'(bus.dequeue_addr), 32'h100);
        checkOutput("t1_deq_idx", 32'(bus.dequeue_idx), 32'd0);
        checkOutput("t1_occupancy", 32'(bus.occupancy), 32'd1);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyResponse(3'd0);
        #1;
        checkOutput("t1_wake", 32'(bus.wake_bitmap), 32'h1);
        nextCycle();
        #1;
        checkOutput("t1_occ_after", 32'(bus.occupancy), 32'd0);
        checkOutput("t1_deq_empty", 32'(bus.dequeue_ready), 32'd0);

        // Merge of two non-synchronized misses to the same line.
        doReset();
        applyMiss(26'h200, 2'd1, 1'b0);
        nextCycle();
        applyMiss(26'h200, 2'd2, 1'b0);
        #1;
        checkOutput("t2_merge_ready", 32'(bus.miss_ready), 32'd1);
        nextCycle();
        #1;
        checkOutput("t2_occupancy", 32'(bus.occupancy), 32'd1);
        checkOutput("t2_deq_idx", 32'(bus.dequeue_idx), 32'd0);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyResponse(3'd0);
        #1;
        checkOutput("t2_wake", 32'(bus.wake_bitmap), 32'b0110);
        nextCycle();
        #1;
        checkOutput("t2_occ_after", 32'(bus.occupancy), 32'd0);

        // A synchronized miss never merges.
        doReset();
        applyMiss(26'h300, 2'd1, 1'b0);
        nextCycle();
        applyMiss(26'h300, 2'd3, 1'b1);
        nextCycle();
        #1;
        checkOutput("t3_occupancy", 32'(bus.occupancy), 32'd2);
        checkOutput("t3_first_idx", 32'(bus.dequeue_idx), 32'd0);
        checkOutput("t3_first_sync", 32'(bus.dequeue_synchronized), 32'd0);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        #1;
        checkOutput("t3_second_idx", 32'(bus.dequeue_idx), 32'd1);
        checkOutput("t3_second_sync", 32'(bus.dequeue_synchronized), 32'd1);
        checkOutput("t3_second_addr", 32'(bus.dequeue_addr), 32'h300);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        #1;
        checkOutput("t3_deq_empty", 32'(bus.dequeue_ready), 32'd0);
        applyResponse(3'd0);
        #1;
        checkOutput("t3_wake0", 32'(bus.wake_bitmap), 32'b0010);
        nextCycle();
        applyResponse(3'd1);
        #1;
        checkOutput("t3_wake1", 32'(bus.wake_bitmap), 32'b1000);
        nextCycle();
        #1;
        checkOutput("t3_occ_after", 32'(bus.occupancy), 32'd0);

        // Full queue: drop new lines, still merge resident ones, freed slot usable next cycle.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyMiss(26'h1000 + 26'(i), 2'(i % 4), 1'b0);
            nextCycle();
        end
        #1;
        checkOutput("t4_occ_full", 32'(bus.occupancy), 32'd8);
        applyMiss(26'h2000, 2'd0, 1'b0);
        #1;
        checkOutput("t4_full_ready", 32'(bus.miss_ready), 32'd0);
        nextCycle();
        #1;
        checkOutput("t4_dropped_occ", 32'(bus.occupancy), 32'd8);
        applyMiss(26'h1003, 2'd0, 1'b0);
        #1;
        checkOutput("t4_full_merge_ready", 32'(bus.miss_ready), 32'd1);
        nextCycle();
        #1;
        checkOutput("t4_merge_occ", 32'(bus.occupancy), 32'd8);
        checkOutput("t4_grant0", 32'(bus.dequeue_idx), 32'd0);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyResponse(3'd0);
        applyMiss(26'h2000, 2'd1, 1'b0);
        #1;
        checkOutput("t4_resp_cycle_ready", 32'(bus.miss_ready), 32'd0);
        checkOutput("t4_wake0", 32'(bus.wake_bitmap), 32'b0001);
        nextCycle();
        applyMiss(26'h2000, 2'd1, 1'b0);
        #1;
        checkOutput("t4_next_cycle_ready", 32'(bus.miss_ready), 32'd1);
        nextCycle();
        #1;
        checkOutput("t4_realloc_occ", 32'(bus.occupancy), 32'd8);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("t4_grant%0d", i), 32'(bus.dequeue_idx), 32'(i));
            bus.dequeue_ack = 1'b1;
            nextCycle();
            #1;
        end
        applyResponse(3'd3);
        #1;
        checkOutput("t4_wake3_merged", 32'(bus.wake_bitmap), 32'b1001);
        nextCycle();
        #1;
        checkOutput("t4_occ_after", 32'(bus.occupancy), 32'd7);

        // Reset asserted with entries live clears everything at once.
        reset = 1'b1;
        #1;
        checkOutput("t5_midreset_occ", 32'(bus.occupancy), 32'd0);
        checkOutput("t5_midreset_deq", 32'(bus.dequeue_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin order and wrap-around of the grant pointer.
        for (int i = 0; i < 4; i++) begin
            applyMiss(26'h40 + 26'(i), 2'd0, 1'b0);
            nextCycle();
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_rr_grant%0d", i), 32'(bus.dequeue_idx), 32'(i));
            bus.dequeue_ack = 1'b1;
            nextCycle();
            #1;
        end
        checkOutput("t5_all_sent", 32'(bus.dequeue_ready), 32'd0);
        applyResponse(3'd1);
        #1;
        checkOutput("t5_wake1", 32'(bus.wake_bitmap), 32'b0001);
        nextCycle();
        applyMiss(26'h50, 2'd2, 1'b0);
        nextCycle();
        applyMiss(26'h51, 2'd3, 1'b0);
        nextCycle();
        #1;
        checkOutput("t5_wrap_first_idx", 32'(bus.dequeue_idx), 32'd4);
        checkOutput("t5_wrap_first_addr", 32'(bus.dequeue_addr), 32'h51);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        #1;
        checkOutput("t5_wrap_second_idx", 32'(bus.dequeue_idx), 32'd1);
        checkOutput("t5_wrap_second_addr", 32'(bus.dequeue_addr), 32'h50);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        #1;
        checkOutput("t5_wrap_empty", 32'(bus.dequeue_ready), 32'd0);
        checkOutput("t5_occupancy", 32'(bus.occupancy), 32'd5);

        // Cancellation: partial, sole waiter, same-cycle with response, and losing to a merge.
        doReset();
        applyMiss(26'h600, 2'd0, 1'b0);
        nextCycle();
        applyMiss(26'h600, 2'd2, 1'b0);
        nextCycle();
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyCancel(2'd2);
        nextCycle();
        applyResponse(3'd0);
        #1;
        checkOutput("t6_cancel_partial", 32'(bus.wake_bitmap), 32'b0001);
        nextCycle();
        applyMiss(26'h700, 2'd1, 1'b0);
        nextCycle();
        #1;
        checkOutput("t6_reuse_idx", 32'(bus.dequeue_idx), 32'd0);
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyCancel(2'd1);
        nextCycle();
        #1;
        checkOutput("t6_orphan_occ", 32'(bus.occupancy), 32'd1);
        applyResponse(3'd0);
        #1;
        checkOutput("t6_cancel_sole", 32'(bus.wake_bitmap), 32'd0);
        nextCycle();
        #1;
        checkOutput("t6_orphan_freed", 32'(bus.occupancy), 32'd0);
        applyMiss(26'h800, 2'd0, 1'b0);
        nextCycle();
        applyMiss(26'h800, 2'd3, 1'b0);
        nextCycle();
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyResponse(3'd0);
        applyCancel(2'd3);
        #1;
        checkOutput("t6_cancel_same_cycle", 32'(bus.wake_bitmap), 32'b0001);
        nextCycle();
        applyMiss(26'h900, 2'd0, 1'b0);
        nextCycle();
        applyMiss(26'h900, 2'd2, 1'b0);
        applyCancel(2'd2);
        nextCycle();
        bus.dequeue_ack = 1'b1;
        nextCycle();
        applyResponse(3'd0);
        #1;
        checkOutput("t6_merge_wins", 32'(bus.wake_bitmap), 32'b0101);
        nextCycle();
        #1;
        checkOutput("t6_occ_final", 32'(bus.occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
